// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: loads on ld, decrements on en, stops at zero with a one-cycle tc pulse.
// Optional periodic mode: define DOWN_COUNTER_AUTO_RELOAD_EN to reload from the captured start value.
module down_counter_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             en,
  input  logic [WIDTH-1:0] input_value,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             busy_q, done_q;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] rld_q, rld_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    rld_d   = rld_q;
`endif
    if (ld) begin
      // A load wins over a terminal count due on the same edge.
      cnt_d   = input_value;
      state_d = (input_value != '0) ? S_ARMED : S_DONE;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      rld_d   = input_value;
`endif
    end else if (state_q == S_ARMED && en) begin
      if (cnt_q > WIDTH'(1)) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        cnt_d = rld_q;
`else
        cnt_d   = '0;
        state_d = S_DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      rld_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      // Status flags registered from the next state so they line up with counter.
      busy_q  <= (state_d == S_ARMED);
      done_q  <= (state_d == S_DONE);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      rld_q   <= rld_d;
`endif
    end
  end

  assign counter = cnt_q;
  assign tc      = tc_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Randomized self-checking bench for down_counter_timer against a behavioural timer model.
module tb_down_counter_timer;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, ld, en;
  logic [WIDTH-1:0] input_value;
  logic [WIDTH-1:0] counter;
  logic             busy, done, tc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: remaining count, whether a countdown is running, whether it has expired, tc pulse.
  int unsigned m_count  = 0;
  int unsigned m_period = 0;
  bit          m_running = 0;
  bit          m_expired = 0;
  bit          m_tc      = 0;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld          (ld),
    .en          (en),
    .input_value (input_value),
    .counter     (counter),
    .busy        (busy),
    .done        (done),
    .tc          (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit l, input bit e, input int unsigned v);
    m_tc = 0;
    if (!r) begin
      m_count = 0; m_period = 0; m_running = 0; m_expired = 0;
    end else if (l) begin
      m_count   = v;
      m_period  = v;
      m_running = (v != 0);
      m_expired = (v == 0);
    end else if (m_running && e) begin
      if (m_count == 1) begin
        m_tc = 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        m_count = m_period;
`else
        m_count   = 0;
        m_running = 0;
        m_expired = 1;
`endif
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit l, input bit e, input logic [WIDTH-1:0] v);
    @(negedge clk);
    rst = r; ld = l; en = e; input_value = v;
    @(posedge clk);
    model_edge(r, l, e, int'(v));
    #1;
    check("counter", 32'(counter), m_count);
    check("tc",      32'(tc),      32'(m_tc));
    check("busy",    32'(busy),    32'(m_running));
    check("done",    32'(done),    32'(m_expired));
  endtask

  initial begin
    rst = 1'b0; ld = 1'b0; en = 1'b0; input_value = '0;

    // Reset overrides ld/en.
    step(0, 1, 1, 8'h55);
    step(0, 1, 1, 8'h55);
    check("rst_counter", 32'(counter), 0);
    check("rst_flags",   {29'd0, busy, done, tc}, 0);

    // Load 3, count down with en held; stays at 0 afterwards.
    step(1, 1, 0, 8'd3);
    check("ld3_counter", 32'(counter), 3);
    for (int unsigned i = 0; i < 3; i++) step(1, 0, 1, 8'd0);
    check("ld3_zero", 32'(counter), 0);
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
    check("ld3_tc",   32'(tc), 1);
    check("ld3_done", 32'(done), 1);
    for (int unsigned i = 0; i < 5; i++) step(1, 0, 1, 8'd0);
    check("ld3_hold_tc", 32'(tc), 0);
`endif

    // Gapped enable pattern after load of 5.
    step(1, 1, 0, 8'd5);
    begin
      bit pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
      foreach (pat[i]) step(1, 0, pat[i], 8'd0);
    end

    // Load on the same edge as a pending terminal count.
    step(1, 1, 0, 8'd2);
    step(1, 0, 1, 8'd0);
    check("pre_tc_counter", 32'(counter), 1);
    step(1, 1, 1, 8'd4);
    check("ld_cancel_counter", 32'(counter), 4);
    check("ld_cancel_tc",      32'(tc), 0);
    check("ld_cancel_busy",    32'(busy), 1);

    // Load of zero goes straight to done.
    step(1, 1, 1, 8'd0);
    check("ld0_done", 32'(done), 1);
    for (int unsigned i = 0; i < 4; i++) step(1, 0, 1, 8'd0);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    step(1, 1, 0, 8'd2);
    begin
      int unsigned exp_cnt [6] = '{1, 2, 1, 2, 1, 2};
      foreach (exp_cnt[i]) begin
        step(1, 0, 1, 8'd0);
        check("periodic_counter", 32'(counter), exp_cnt[i]);
        check("periodic_tc",      32'(tc), (i % 2 == 1) ? 1 : 0);
      end
    end
`endif

    // Randomized traffic, including occasional reset and small/zero loads.
    for (int unsigned i = 0; i < 600; i++) begin
      bit r_i = ($urandom_range(99) != 0);
      bit l_i = ($urandom_range(11) == 0);
      bit e_i = ($urandom_range(9) < 7);
      logic [WIDTH-1:0] v_i = ($urandom_range(3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(6));
      step(r_i, l_i, e_i, v_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
